// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file, one byte-enabled synchronous write
// port and two combinational read ports. Optional hardwired zero entry and
// optional write-to-read bypass so a read sees the value about to be stored.
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wbe,
    input  logic [ADDR_W-1:0]     raddr_a,
    output logic [WIDTH-1:0]      rdata_a,
    input  logic [ADDR_W-1:0]     raddr_b,
    output logic [WIDTH-1:0]      rdata_b
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Word that entry[waddr] will hold after the edge: enabled lanes take new
    // data, the rest keep the stored byte. Shared by the write path and bypass.
    logic [WIDTH-1:0] wr_merge;
    logic             wr_zero;
    logic             wr_en;
    logic             byp_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign wr_merge[8*gi +: 8] = wbe[gi] ? wdata[8*gi +: 8]
                                                 : mem_q[waddr][8*gi +: 8];
        end
    endgenerate

    // Entry 0 is read-only when hardwired to zero; bypass never applies in reset.
    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_en   = we && !wr_zero;
    assign byp_ok  = (BYPASS != 0) && rst_n && we && !wr_zero;

    // Next-state of the storage array: only the addressed entry can change.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[waddr] = wr_merge;
        end
    end

    // Storage flops; reset wins over any write on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Port A read: stored word, bypassed merge on an address hit, zero entry forced.
    always_comb begin
        rdata_a = mem_q[raddr_a];
        if (byp_ok && (raddr_a == waddr)) begin
            rdata_a = wr_merge;
        end
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rdata_a = '0;
        end
    end

    // Port B read: identical rules to port A.
    always_comb begin
        rdata_b = mem_q[raddr_b];
        if (byp_ok && (raddr_b == waddr)) begin
            rdata_b = wr_merge;
        end
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rdata_b = '0;
        end
    end

endmodule
